// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: none; optional feature macro used by muldiv_unit is MULDIV_FAST_MUL_EN.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // funct3[2] separates the divide/remainder group from the multiplies
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_signed_op1(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
  endfunction

  function automatic logic is_signed_op2(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 iteration: conditional add (multiply) or restoring subtract (divide).
// Latency: purely combinational.
// Backpressure: none; the owning unit decides when the step result is committed.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_operand,
  input  logic            i_sub,
  input  logic            i_bit,
  output logic [XLEN:0]   o_acc,
  output logic            o_qbit
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // Add mode: i_bit is the multiplier LSB gating the add, carry kept in o_acc[XLEN].
  // Subtract mode: i_bit is the next dividend bit shifted into the partial remainder.
  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_bit ? {1'b0, i_operand} : '0);
    w_shift = {i_acc, i_bit};
    w_diff  = w_shift - {1'b0, i_operand};
    o_qbit  = 1'b0;
    o_acc   = w_sum;
    if (i_sub) begin
      // no borrow out of the top bit means the divisor fits: keep the difference
      o_qbit = ~w_diff[XLEN];
      o_acc  = o_qbit ? w_diff : w_shift;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide/remainder unit, iterative radix-2, start/busy/done handshake.
// Latency: XLEN+1 edges from accept to done; 1 edge for div-by-zero/overflow (and multiplies with MULDIV_FAST_MUL_EN).
// Backpressure: start ignored while busy; accepted in IDLE or in the DONE cycle for back-to-back issue.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_operand1,
  input  logic [XLEN-1:0] i_operand2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_func3;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic            r_bypass;
  logic [XLEN-1:0] r_opd;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;

  logic            w_accept;
  logic            w_op1_neg;
  logic            w_op2_neg;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic            w_fast;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN:0]   w_iter_acc;
  logic            w_iter_qbit;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_signed;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fix_res;
  logic            w_busy_nxt;
  logic            w_done_nxt;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
`endif

  // Decode the incoming request: signs, magnitudes and the RISC-V special cases
  always_comb begin
    w_accept  = i_start && ((r_state == IDLE) || (r_state == DONE));
    w_op1_neg = is_signed_op1(i_func3) & i_operand1[XLEN-1];
    w_op2_neg = is_signed_op2(i_func3) & i_operand2[XLEN-1];
    w_abs1    = w_op1_neg ? -i_operand1 : i_operand1;
    w_abs2    = w_op2_neg ? -i_operand2 : i_operand2;
    w_div0    = is_div(i_func3) && (i_operand2 == '0);
    w_ovf     = is_div(i_func3) && is_signed_op1(i_func3) &&
                (i_operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_operand2 == '1);
    w_special = w_div0 || w_ovf;
    // funct3[1] selects remainder within the divide group
    if (i_func3[1]) w_special_res = w_div0 ? i_operand1 : '0;
    else            w_special_res = w_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
    w_fast      = ~is_div(i_func3);
    // low 2*XLEN bits of the sign-extended product are the exact product for all four forms
    w_fast_prod = {{XLEN{w_op1_neg}}, i_operand1} * {{XLEN{w_op2_neg}}, i_operand2};
`else
    w_fast      = 1'b0;
`endif
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .i_acc     (r_hi),
    .i_operand (r_opd),
    .i_sub     (is_div(r_func3)),
    .i_bit     (is_div(r_func3) ? r_lo[XLEN-1] : r_lo[0]),
    .o_acc     (w_iter_acc),
    .o_qbit    (w_iter_qbit)
  );

  // Sign correction and output selection used in the FIX state
  always_comb begin
    w_prod        = {r_hi, r_lo};
    w_prod_signed = r_neg_res ? -w_prod : w_prod;
    w_quo         = r_neg_res ? -r_lo : r_lo;
    w_rem         = r_neg_rem ? -r_hi : r_hi;
    case (r_func3)
      MD_MUL:                       w_fix_res = w_prod_signed[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod_signed[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_fix_res = w_quo;
      default:                      w_fix_res = w_rem;
    endcase
    if (r_bypass) w_fix_res = r_lo;
  end

  // State register plus the registered busy/done outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) w_state_nxt = (w_special || w_fast) ? FIX : CALC;
        else         w_state_nxt = IDLE;
      end
      CALC:    if (r_cnt == CW'(XLEN-1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode of the upcoming state so busy/done come straight from flops
  always_comb begin
    w_busy_nxt = (w_state_nxt == CALC) || (w_state_nxt == FIX);
    w_done_nxt = (w_state_nxt == DONE);
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_func3   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_bypass  <= 1'b0;
      r_opd     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_func3   <= i_func3;
        r_cnt     <= '0;
        r_neg_res <= w_op1_neg ^ w_op2_neg;
        r_neg_rem <= w_op1_neg;
        r_bypass  <= w_special;
        r_hi      <= '0;
        // multiply adds |op1| under control of |op2| bits; divide subtracts |op2| from |op1|
        r_opd     <= is_div(i_func3) ? w_abs2 : w_abs1;
        r_lo      <= is_div(i_func3) ? w_abs1 : w_abs2;
        if (w_special) r_lo <= w_special_res;
`ifdef MULDIV_FAST_MUL_EN
        if (w_fast) begin
          {r_hi, r_lo} <= w_fast_prod;
          r_neg_res    <= 1'b0;
        end
`endif
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + 1'b1;
        if (is_div(r_func3)) begin
          r_hi <= w_iter_acc[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], w_iter_qbit};
        end else begin
          r_hi <= w_iter_acc[XLEN:1];
          r_lo <= {w_iter_acc[0], r_lo[XLEN-1:1]};
        end
      end
      if (r_state == FIX) r_result <= w_fix_res;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit with a behavioural reference model.
// Latency: model predicts done at accept edge + XLEN+1 (or +1 for special cases).
// Backpressure: driver only issues when busy is low and pulses stray starts while busy.
`timescale 1ns/1ps
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_func3    (func3),
    .i_operand1 (op1),
    .i_operand2 (op2),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    int          lat;
  } txn_t;
  txn_t q[$];
  logic [31:0] held = '0;
  bit exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic straight from the ISA definitions, using 64-bit integers
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      MD_MUL:    begin p = sa * sb; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      MD_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == MD_DIV || f == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Per-cycle comparison of done/busy/result against the outstanding-operation model
  always @(negedge clk) begin
    if (chk_en) begin
      exp_done = (q.size() > 0) && ((cyc - q[0].acc) == q[0].lat);
      check("done", {31'b0, done}, {31'b0, exp_done});
      check("busy", {31'b0, busy}, {31'b0, (q.size() > 0) && !exp_done});
      if (exp_done) begin
        check("result", result, q[0].exp);
        held = q[0].exp;
        void'(q.pop_front());
      end else begin
        check("hold", result, held);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit keep_start);
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: busy still %0d after %0d cycles, required 0", busy, w);
    end
    start = 1'b1;
    func3 = f;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1;
    q.push_back('{exp: model(f, a, b), acc: cyc, lat: latency(f, a, b)});
    if (!keep_start) begin
      start = 1'b0;
      // scramble inputs to show they no longer matter once captured
      func3 = 3'($urandom);
      op1   = $urandom;
      op2   = $urandom;
    end
  endtask

  task automatic issue_lit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lit, input bit keep_start);
    check("model_pin", model(f, a, b), lit);
    issue(f, a, b, keep_start);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  d_f   [12] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULHSU, MD_DIV, MD_REM,
                              MD_DIVU, MD_REMU, MD_DIVU, MD_REMU, MD_DIV, MD_REM};
  logic [31:0] d_a   [12] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2,
                              32'h2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

  initial begin
    bit prev_keep;
    bit keep;
    int w;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Directed vectors; odd entries keep start high so the next op launches in DONE
    for (int i = 0; i < 12; i++)
      issue_lit(d_f[i], d_a[i], d_b[i], d_exp[i], (i % 2 == 1) && (i != 11));

    // Stray start while a DIV is in flight must be ignored
    issue_lit(MD_DIV, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    func3 = MD_DIVU;
    op1   = 32'd5;
    op2   = 32'd1;
    @(negedge clk);
    start = 1'b0;

    // Let it finish and idle so the result-hold check runs for a while
    w = 0;
    while (q.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);

    // Reset while the step counter is at 15
    issue(MD_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    held = '0;
    issue_lit(MD_MUL, 32'd3, 32'd4, 32'd12, 1'b0);

    // Randomised traffic with gaps and back-to-back launches
    prev_keep = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (!prev_keep) repeat ($urandom % 3) @(negedge clk);
      keep = (i != 149) && ($urandom % 4 == 0);
      issue(3'($urandom), pick(), pick(), keep);
      prev_keep = keep;
    end

    // Drain
    w = 0;
    while (q.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d operations still pending, required 0", q.size());
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
